// File: rtl/fir_seq_pkg.sv
// Shared types and helpers for the FIR stream sequencer: FSM state encoding,
// output saturation limits and the accumulator-to-sample saturate function.
package fir_seq_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      FLUSH = 2'd2
   } seq_state_t;

   localparam int ACC_W = 32;
   localparam int OUT_W = 8;

   localparam logic signed [ACC_W-1:0] SAT_MAX = 127;
   localparam logic signed [ACC_W-1:0] SAT_MIN = -128;

   // Clamp a signed accumulator value into the signed output sample range.
   function automatic logic signed [OUT_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
      logic signed [OUT_W-1:0] res;
      if (v > SAT_MAX)
         res = SAT_MAX[OUT_W-1:0];
      else if (v < SAT_MIN)
         res = SAT_MIN[OUT_W-1:0];
      else
         res = v[OUT_W-1:0];
      return res;
   endfunction

endpackage

// File: rtl/fir_stream_sequencer_sample_fifo.sv
// sample_fifo: small synchronous FIFO with full/empty flags and same-cycle
// push/pop; a push into a full FIFO is accepted only alongside a pop.
module sample_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign dout    = mem[rd_ptr];

   // Storage is reset too so the head (and thus the AXI data) reads 0 after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fir_stream_sequencer.sv
// FIR stream sequencer: buffers samples into the FIR s_axis port, rescales FIR
// results to 8-bit, and flushes the filter delay line. Optional FIR_SEQ_STATS_EN adds counters.
//
// state | meaning
// RUN   | normal streaming; samples accepted into the FIFO
// DRAIN | flush requested; emptying queued samples into the FIR
// FLUSH | pushing FLUSH_TAPS zero samples to clear the FIR delay line
module fir_stream_sequencer
   import fir_seq_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int IN_WIDTH    = 8,
   parameter int TDATA_WIDTH = 16,
   parameter int ACC_WIDTH   = 32,
   parameter int FLUSH_TAPS  = 10
) (
   input  logic                   clk_in,
   input  logic                   rst_n_in,
   input  logic [IN_WIDTH-1:0]    sample_in,
   input  logic                   sample_valid_in,
   input  logic                   flush_in,
   input  logic [4:0]             shift_in,
   output logic [TDATA_WIDTH-1:0] s_axis_tdata_out,
   output logic                   s_axis_tvalid_out,
   input  logic                   s_axis_tready_in,
   input  logic [ACC_WIDTH-1:0]   m_axis_tdata_in,
   input  logic                   m_axis_tvalid_in,
   output logic [IN_WIDTH-1:0]    filt_out,
   output logic                   filt_valid_out,
   output logic                   busy_out,
`ifdef FIR_SEQ_STATS_EN
   output logic [15:0]            drop_count_out,
   output logic [15:0]            out_count_out,
`endif
   output logic                   overflow_out
);

   localparam int CW = $clog2(FLUSH_TAPS + 1);

   seq_state_t                  state;
   seq_state_t                  state_next;
   logic [CW-1:0]               flush_cnt;
   logic [IN_WIDTH-1:0]         fifo_head;
   logic                        fifo_full;
   logic                        fifo_empty;
   logic                        fifo_push;
   logic                        fifo_pop;
   logic                        xfer;
   logic                        drop_run;
   logic signed [ACC_WIDTH-1:0] shifted;

   sample_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (IN_WIDTH)
   ) u_fifo (
      .clk   (clk_in),
      .rst_n (rst_n_in),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (sample_in),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign xfer      = s_axis_tvalid_out && s_axis_tready_in;
   assign fifo_pop  = xfer && (state != FLUSH);
   assign fifo_push = (state == RUN) && sample_valid_in && (!fifo_full || fifo_pop);
   assign drop_run  = (state == RUN) && sample_valid_in && fifo_full && !fifo_pop;
   assign shifted   = $signed(m_axis_tdata_in) >>> shift_in;

   always_comb begin
      state_next        = state;
      s_axis_tvalid_out = 1'b0;
      s_axis_tdata_out  = '0;
      case (state)
         RUN: begin
            s_axis_tvalid_out = !fifo_empty;
            s_axis_tdata_out  = {{(TDATA_WIDTH-IN_WIDTH){fifo_head[IN_WIDTH-1]}}, fifo_head};
            if (flush_in) state_next = DRAIN;
         end
         DRAIN: begin
            s_axis_tvalid_out = !fifo_empty;
            s_axis_tdata_out  = {{(TDATA_WIDTH-IN_WIDTH){fifo_head[IN_WIDTH-1]}}, fifo_head};
            if (fifo_empty) state_next = FLUSH;
         end
         FLUSH: begin
            s_axis_tvalid_out = (flush_cnt != '0);
            if (xfer && flush_cnt == CW'(1)) state_next = RUN;
         end
         default: state_next = RUN;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state          <= RUN;
         busy_out       <= 1'b0;
         flush_cnt      <= '0;
         overflow_out   <= 1'b0;
         filt_out       <= '0;
         filt_valid_out <= 1'b0;
      end else begin
         state    <= state_next;
         busy_out <= (state_next != RUN);
         if (state == DRAIN && fifo_empty)
            flush_cnt <= CW'(FLUSH_TAPS);
         else if (state == FLUSH && xfer)
            flush_cnt <= flush_cnt - CW'(1);
         if (drop_run) overflow_out <= 1'b1;
         filt_valid_out <= m_axis_tvalid_in;
         if (m_axis_tvalid_in) filt_out <= saturate(shifted);
      end
   end

`ifdef FIR_SEQ_STATS_EN
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         drop_count_out <= '0;
         out_count_out  <= '0;
      end else begin
         if (drop_run && drop_count_out != 16'hFFFF) drop_count_out <= drop_count_out + 16'd1;
         if (filt_valid_out && out_count_out != 16'hFFFF) out_count_out <= out_count_out + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fir_stream_sequencer.sv
// Directed self-checking bench for fir_stream_sequencer (default build).
module tb_fir_stream_sequencer;

   logic        clk;
   logic        rst_n;
   logic [7:0]  sample;
   logic        sample_valid;
   logic        flush;
   logic [4:0]  shift;
   logic [15:0] s_tdata;
   logic        s_tvalid;
   logic        s_tready;
   logic [31:0] m_tdata;
   logic        m_tvalid;
   logic [7:0]  filt;
   logic        filt_valid;
   logic        busy;
   logic        overflow;

   int vectors = 0;
   int errors  = 0;
   logic [15:0] rx_q[$];

   fir_stream_sequencer dut (
      .clk_in            (clk),
      .rst_n_in          (rst_n),
      .sample_in         (sample),
      .sample_valid_in   (sample_valid),
      .flush_in          (flush),
      .shift_in          (shift),
      .s_axis_tdata_out  (s_tdata),
      .s_axis_tvalid_out (s_tvalid),
      .s_axis_tready_in  (s_tready),
      .m_axis_tdata_in   (m_tdata),
      .m_axis_tvalid_in  (m_tvalid),
      .filt_out          (filt),
      .filt_valid_out    (filt_valid),
      .busy_out          (busy),
      .overflow_out      (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Everything the FIR side accepts, in order.
   always @(posedge clk) begin
      if (rst_n && s_tvalid && s_tready) rx_q.push_back(s_tdata);
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      sample_valid = 1'b0;
      flush = 1'b0;
      m_tvalid = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({s_tvalid, s_tdata, filt, filt_valid, busy, overflow} !== 28'h0) begin
         errors++;
         $display("FAIL reset_outputs: got tvalid=%b tdata=%h filt=%h fv=%b busy=%b ovf=%b, want all 0",
                  s_tvalid, s_tdata, filt, filt_valid, busy, overflow);
      end
      do_reset();
      vectors++;
      if (s_tvalid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got tvalid=%b busy=%b, want 0 0", s_tvalid, busy);
      end
   endtask

   task automatic test_stream();
      rx_q.delete();
      s_tready = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         sample = 8'(i);
         sample_valid = 1'b1;
         tick();
         sample_valid = 1'b0;
         repeat (15) tick();
      end
      vectors++;
      if (rx_q.size() != 20) begin
         errors++;
         $display("FAIL stream_count: got %0d transfers, want 20", rx_q.size());
      end else begin
         for (int i = 0; i < 20; i++) begin
            vectors++;
            if (rx_q[i] !== 16'(i + 1)) begin
               errors++;
               $display("FAIL stream_data[%0d]: got %h, want %h", i, rx_q[i], 16'(i + 1));
            end
         end
      end
      vectors++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL stream_overflow: got %b, want 0", overflow);
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] exp_bp [4] = '{16'd10, 16'd20, 16'd30, 16'd40};
      rx_q.delete();
      s_tready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         sample = 8'((i + 1) * 10);
         sample_valid = 1'b1;
         tick();
      end
      sample_valid = 1'b0;
      repeat (94) tick();
      vectors++;
      if (s_tvalid !== 1'b1 || s_tdata !== 16'd10 || overflow !== 1'b1 || rx_q.size() != 0) begin
         errors++;
         $display("FAIL bp_stalled: got tvalid=%b tdata=%h ovf=%b rx=%0d, want 1 000a 1 0",
                  s_tvalid, s_tdata, overflow, rx_q.size());
      end
      s_tready = 1'b1;
      repeat (8) tick();
      vectors++;
      if (rx_q.size() != 4) begin
         errors++;
         $display("FAIL bp_count: got %0d transfers, want 4", rx_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            vectors++;
            if (rx_q[i] !== exp_bp[i]) begin
               errors++;
               $display("FAIL bp_data[%0d]: got %h, want %h", i, rx_q[i], exp_bp[i]);
            end
         end
      end
      vectors++;
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL bp_overflow_sticky: got %b, want 1", overflow);
      end
   endtask

   task automatic test_sign_hold();
      do_reset();
      vectors++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL hold_ovf_cleared: got %b, want 0", overflow);
      end
      rx_q.delete();
      s_tready = 1'b0;
      sample = 8'hFD;
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if (s_tvalid !== 1'b1 || s_tdata !== 16'hFFFD) begin
            errors++;
            $display("FAIL hold_stable[%0d]: got tvalid=%b tdata=%h, want 1 fffd", i, s_tvalid, s_tdata);
         end
         tick();
      end
      s_tready = 1'b1;
      tick();
      vectors++;
      if (rx_q.size() != 1 || s_tvalid !== 1'b0) begin
         errors++;
         $display("FAIL hold_xfer: got rx=%0d tvalid=%b, want 1 0", rx_q.size(), s_tvalid);
      end else if (rx_q[0] !== 16'hFFFD) begin
         errors++;
         $display("FAIL hold_xfer_data: got %h, want fffd", rx_q[0]);
      end
   endtask

   task automatic test_saturation();
      logic [31:0] din [4] = '{32'h0001_0000, 32'hFFFF_0000, 32'h0000_0500, 32'hFFFF_FB00};
      logic [7:0]  dexp[4] = '{8'h7F, 8'h80, 8'h05, 8'hFB};
      shift = 5'd8;
      for (int i = 0; i < 4; i++) begin
         m_tdata = din[i];
         m_tvalid = 1'b1;
         #1;
         vectors++;
         if (filt_valid !== 1'b0) begin
            errors++;
            $display("FAIL sat_early[%0d]: got fv=%b, want 0", i, filt_valid);
         end
         tick();
         m_tvalid = 1'b0;
         m_tdata = 32'h1234_5678;
         vectors++;
         if (filt_valid !== 1'b1 || filt !== dexp[i]) begin
            errors++;
            $display("FAIL sat_value[%0d]: got fv=%b filt=%h, want 1 %h", i, filt_valid, filt, dexp[i]);
         end
         tick();
         vectors++;
         if (filt_valid !== 1'b0 || filt !== dexp[i]) begin
            errors++;
            $display("FAIL sat_hold[%0d]: got fv=%b filt=%h, want 0 %h", i, filt_valid, filt, dexp[i]);
         end
      end
   endtask

   task automatic test_flush();
      bit done = 0;
      logic [7:0] q_in [3] = '{8'd7, 8'd8, 8'd9};
      do_reset();
      rx_q.delete();
      s_tready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sample = q_in[i];
         sample_valid = 1'b1;
         tick();
      end
      sample_valid = 1'b0;
      s_tready = 1'b1;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      vectors++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL flush_busy_rise: got %b, want 1", busy);
      end
      for (int cyc = 0; cyc < 60 && !done; cyc++) begin
         if (cyc == 5) begin
            sample = 8'h33;
            sample_valid = 1'b1;
         end
         tick();
         sample_valid = 1'b0;
         if (!busy) done = 1;
      end
      vectors++;
      if (!done) begin
         errors++;
         $display("FAIL flush_timeout: got busy=%b after 60 cycles, want 0", busy);
      end
      vectors++;
      if (rx_q.size() != 13) begin
         errors++;
         $display("FAIL flush_count: got %0d transfers, want 13", rx_q.size());
      end else begin
         for (int i = 0; i < 13; i++) begin
            logic [15:0] e;
            e = (i < 3) ? {8'h00, q_in[i]} : 16'h0000;
            vectors++;
            if (rx_q[i] !== e) begin
               errors++;
               $display("FAIL flush_data[%0d]: got %h, want %h", i, rx_q[i], e);
            end
         end
      end
      vectors++;
      if (overflow !== 1'b0 || s_tvalid !== 1'b0) begin
         errors++;
         $display("FAIL flush_drop: got ovf=%b tvalid=%b, want 0 0", overflow, s_tvalid);
      end
   endtask

   task automatic test_reset_mid_flush();
      bit reached = 0;
      do_reset();
      rx_q.delete();
      s_tready = 1'b1;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      shift = 5'd8;
      m_tdata = 32'h0000_0300;
      m_tvalid = 1'b1;
      tick();
      m_tvalid = 1'b0;
      vectors++;
      if (filt_valid !== 1'b1 || filt !== 8'h03 || busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_result: got fv=%b filt=%h busy=%b, want 1 03 1", filt_valid, filt, busy);
      end
      for (int cyc = 0; cyc < 40 && !reached; cyc++) begin
         if (rx_q.size() >= 4) reached = 1;
         else tick();
      end
      vectors++;
      if (!reached || rx_q.size() != 4 || busy !== 1'b1) begin
         errors++;
         $display("FAIL midflush_progress: got rx=%0d busy=%b, want 4 1", rx_q.size(), busy);
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({s_tvalid, s_tdata, filt, filt_valid, busy, overflow} !== 28'h0) begin
         errors++;
         $display("FAIL midflush_reset: got tvalid=%b tdata=%h filt=%h fv=%b busy=%b ovf=%b, want all 0",
                  s_tvalid, s_tdata, filt, filt_valid, busy, overflow);
      end
      @(negedge clk);
      tick();
      rst_n = 1'b1;
      tick();
      rx_q.delete();
      sample = 8'h25;
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      tick();
      vectors++;
      if (rx_q.size() != 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_sample: got rx=%0d busy=%b, want 1 0", rx_q.size(), busy);
      end else if (rx_q[0] !== 16'h0025) begin
         errors++;
         $display("FAIL post_reset_data: got %h, want 0025", rx_q[0]);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      sample = '0;
      sample_valid = 1'b0;
      flush = 1'b0;
      shift = '0;
      s_tready = 1'b0;
      m_tdata = '0;
      m_tvalid = 1'b0;
      @(negedge clk);
      test_reset();
      test_stream();
      test_backpressure();
      test_sign_hold();
      test_saturation();
      test_flush();
      test_reset_mid_flush();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
